// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register bank: the CPU's data and
// address widths plus the index of the hard-wired zero register.
package regfile_sb_pkg;
   localparam int WIDTH_DEF = 8;
   localparam int AW_DEF    = 4;
   localparam int REG_ZERO  = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// Datapath/controller bundle for the register bank: write port, two read
// ports with use qualifiers, reserve request and scoreboard status.
interface regfile_sb_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
);
   logic             we3;
   logic [AW-1:0]    wa3;
   logic [WIDTH-1:0] wd3;
   logic [AW-1:0]    ra1;
   logic [AW-1:0]    ra2;
   logic             ren1;
   logic             ren2;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic             rsv;
   logic [AW-1:0]    rsa;
   logic             rsv_ack;
   logic             busy1;
   logic             busy2;
   logic             stall;
   logic [AW:0]      pending;

   modport master (
      output we3, wa3, wd3, ra1, ra2, ren1, ren2, rsv, rsa,
      input  rd1, rd2, rsv_ack, busy1, busy2, stall, pending
   );

   modport slave (
      input  we3, wa3, wd3, ra1, ra2, ren1, ren2, rsv, rsa,
      output rd1, rd2, rsv_ack, busy1, busy2, stall, pending
   );
endinterface

// File: rtl/regfile_sb_score.sv
// Busy scoreboard: one reservation bit per register, a running count of
// outstanding reservations, and the combinational accept/busy decisions.
module regfile_sb_score
   import regfile_sb_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we3,
   input  logic [AW-1:0] wa3,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   input  logic          rsv,
   input  logic [AW-1:0] rsa,
   output logic          rsv_ack,
   output logic          busy1,
   output logic          busy2,
   output logic [AW:0]   pending
);
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [AW:0]      pending_q;
   logic [AW:0]      pending_d;
   logic             wr_valid;
   logic             clr;

   assign wr_valid = we3 && (wa3 != ZERO_ADDR);

   // Accept/clear decisions; a same-cycle write hides a pending hazard.
   always_comb begin
      rsv_ack = rsv && (rsa != ZERO_ADDR) &&
                (!busy_q[rsa] || (wr_valid && (wa3 == rsa)));
      clr     = wr_valid && busy_q[wa3];
      busy1   = (ra1 != ZERO_ADDR) && busy_q[ra1] && !(we3 && (wa3 == ra1));
      busy2   = (ra2 != ZERO_ADDR) && busy_q[ra2] && !(we3 && (wa3 == ra2));
      pending_d = pending_q;
      if (rsv_ack && !clr) begin
         pending_d = pending_q + (AW + 1)'(1);
      end else if (clr && !rsv_ack) begin
         pending_d = pending_q - (AW + 1)'(1);
      end
   end

   // A new reservation wins over a clear of the same register.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign busy_d[gi] = (rsv_ack && (rsa == AW'(gi))) ? 1'b1 :
                          (clr && (wa3 == AW'(gi)))     ? 1'b0 :
                          busy_q[gi];
   end

   // Scoreboard state; reset drops every reservation at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q    <= '0;
         pending_q <= '0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;
endmodule

// File: rtl/regfile_sb.sv
// Register bank with zero register, write-to-read bypass, asynchronous
// clear and a reservation scoreboard that drives the reader stall.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = AW_DEF
) (
   input logic         clk,
   input logic         reset,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

   logic [WIDTH-1:0] regb_q [DEPTH];
   logic             wr_valid;

   assign wr_valid = bus.we3 && (bus.wa3 != ZERO_ADDR);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      // Per-register storage; address 0 never matches a valid write.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            regb_q[gi] <= '0;
         end else if (wr_valid && (bus.wa3 == AW'(gi))) begin
            regb_q[gi] <= bus.wd3;
         end
      end
   end

   // Read ports: zero register first, then bypass, then storage.
   always_comb begin
      bus.rd1 = regb_q[bus.ra1];
      if (bus.ra1 == ZERO_ADDR) begin
         bus.rd1 = '0;
      end else if (bus.we3 && (bus.wa3 == bus.ra1)) begin
         bus.rd1 = bus.wd3;
      end
   end

   // Second read port, same priority as the first.
   always_comb begin
      bus.rd2 = regb_q[bus.ra2];
      if (bus.ra2 == ZERO_ADDR) begin
         bus.rd2 = '0;
      end else if (bus.we3 && (bus.wa3 == bus.ra2)) begin
         bus.rd2 = bus.wd3;
      end
   end

   regfile_sb_score #(.AW(AW)) u_score (
      .clk     (clk),
      .reset   (reset),
      .we3     (bus.we3),
      .wa3     (bus.wa3),
      .ra1     (bus.ra1),
      .ra2     (bus.ra2),
      .rsv     (bus.rsv),
      .rsa     (bus.rsa),
      .rsv_ack (bus.rsv_ack),
      .busy1   (bus.busy1),
      .busy2   (bus.busy2),
      .pending (bus.pending)
   );

   assign bus.stall = (bus.ren1 && bus.busy1) || (bus.ren2 && bus.busy2);
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios then randomized traffic checked
// against an array/bit-vector model of the register bank and reservations.
module tb_regfile_sb;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   regfile_sb_if #(.WIDTH(8), .AW(4)) bus ();

   regfile_sb #(.WIDTH(8), .AW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model
   logic [7:0] m_mem  [16];
   bit         m_busy [16];

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_mem[i]  = 8'h00;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [7:0] exp_rd(input logic [3:0] ra);
      if (ra == 4'd0) return 8'h00;
      if (bus.we3 && bus.wa3 == ra) return bus.wd3;
      return m_mem[ra];
   endfunction

   function automatic logic exp_busy(input logic [3:0] ra);
      return (ra != 4'd0) && m_busy[ra] && !(bus.we3 && bus.wa3 == ra);
   endfunction

   function automatic logic exp_ack();
      return bus.rsv && (bus.rsa != 4'd0) &&
             (!m_busy[bus.rsa] || (bus.we3 && bus.wa3 == bus.rsa));
   endfunction

   function automatic logic [4:0] exp_pending();
      int c = 0;
      for (int i = 0; i < 16; i++) c += int'(m_busy[i]);
      return 5'(c);
   endfunction

   task automatic idle();
      bus.we3 = 0; bus.wa3 = 0; bus.wd3 = 0;
      bus.ra1 = 0; bus.ra2 = 0; bus.ren1 = 0; bus.ren2 = 0;
      bus.rsv = 0; bus.rsa = 0;
   endtask

   // Apply the current inputs as one clock cycle to model and DUT.
   task automatic tick();
      logic ack;
      ack = exp_ack();
      if (bus.we3 && bus.wa3 != 4'd0) begin
         m_mem[bus.wa3]  = bus.wd3;
         m_busy[bus.wa3] = 1'b0;
      end
      if (ack) m_busy[bus.rsa] = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      bus.ra1 = 4'd5; bus.ra2 = 4'd0; bus.ren1 = 1; bus.ren2 = 1;
      model_reset();
      #1;
      n_cmp++; if (bus.rd1 !== 8'h00) begin n_err++; $display("FAIL reset_rd1 got %h want 00", bus.rd1); end
      n_cmp++; if (bus.rd2 !== 8'h00) begin n_err++; $display("FAIL reset_rd2 got %h want 00", bus.rd2); end
      n_cmp++; if (bus.pending !== 5'd0) begin n_err++; $display("FAIL reset_pending got %0d want 0", bus.pending); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall); end
      bus.rsv = 1; bus.rsa = 4'd5; #1;
      n_cmp++; if (bus.rsv_ack !== 1'b1) begin n_err++; $display("FAIL reset_ack5 got %b want 1", bus.rsv_ack); end
      bus.rsa = 4'd0; #1;
      n_cmp++; if (bus.rsv_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack0 got %b want 0", bus.rsv_ack); end
      idle();
      reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_bypass();
      idle();
      bus.we3 = 1; bus.wa3 = 4'd3; bus.wd3 = 8'hA5; bus.ra1 = 4'd3; #1;
      n_cmp++; if (bus.rd1 !== 8'hA5) begin n_err++; $display("FAIL bypass_rd1 got %h want a5", bus.rd1); end
      tick();
      idle(); bus.ra1 = 4'd3; #1;
      n_cmp++; if (bus.rd1 !== 8'hA5) begin n_err++; $display("FAIL stored_rd1 got %h want a5", bus.rd1); end
      $display("test_bypass done");
   endtask

   task automatic test_zero_reg();
      idle();
      bus.we3 = 1; bus.wa3 = 4'd0; bus.wd3 = 8'hFF; bus.ra1 = 4'd0; #1;
      n_cmp++; if (bus.rd1 !== 8'h00) begin n_err++; $display("FAIL zero_bypass got %h want 00", bus.rd1); end
      tick();
      idle(); bus.ra1 = 4'd0; bus.rsv = 1; bus.rsa = 4'd0; #1;
      n_cmp++; if (bus.rd1 !== 8'h00) begin n_err++; $display("FAIL zero_read got %h want 00", bus.rd1); end
      n_cmp++; if (bus.rsv_ack !== 1'b0) begin n_err++; $display("FAIL zero_ack got %b want 0", bus.rsv_ack); end
      tick();
      idle(); #1;
      n_cmp++; if (bus.pending !== 5'd0) begin n_err++; $display("FAIL zero_pending got %0d want 0", bus.pending); end
      $display("test_zero_reg done");
   endtask

   task automatic test_reserve();
      idle(); bus.rsv = 1; bus.rsa = 4'd7; #1;
      n_cmp++; if (bus.rsv_ack !== 1'b1) begin n_err++; $display("FAIL rsv7_ack got %b want 1", bus.rsv_ack); end
      tick();
      idle(); bus.ra2 = 4'd7; bus.ren2 = 1; #1;
      n_cmp++; if (bus.pending !== 5'd1) begin n_err++; $display("FAIL rsv7_pending got %0d want 1", bus.pending); end
      n_cmp++; if (bus.busy2 !== 1'b1) begin n_err++; $display("FAIL rsv7_busy2 got %b want 1", bus.busy2); end
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rsv7_stall got %b want 1", bus.stall); end
      bus.ren2 = 0; #1;
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL unused_port_stall got %b want 0", bus.stall); end
      bus.ren2 = 1; bus.rsv = 1; bus.rsa = 4'd7; #1;
      n_cmp++; if (bus.rsv_ack !== 1'b0) begin n_err++; $display("FAIL double_rsv_ack got %b want 0", bus.rsv_ack); end
      tick();
      idle(); bus.we3 = 1; bus.wa3 = 4'd7; bus.wd3 = 8'h3C; bus.ra2 = 4'd7; bus.ren2 = 1; #1;
      n_cmp++; if (bus.busy2 !== 1'b0) begin n_err++; $display("FAIL wr7_busy2 got %b want 0", bus.busy2); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL wr7_stall got %b want 0", bus.stall); end
      n_cmp++; if (bus.rd2 !== 8'h3C) begin n_err++; $display("FAIL wr7_rd2 got %h want 3c", bus.rd2); end
      tick();
      idle(); #1;
      n_cmp++; if (bus.pending !== 5'd0) begin n_err++; $display("FAIL wr7_pending got %0d want 0", bus.pending); end
      $display("test_reserve done");
   endtask

   task automatic test_same_cycle();
      idle(); bus.rsv = 1; bus.rsa = 4'd2; tick();
      idle(); bus.rsv = 1; bus.rsa = 4'd4; tick();
      idle(); #1;
      n_cmp++; if (bus.pending !== 5'd2) begin n_err++; $display("FAIL two_rsv_pending got %0d want 2", bus.pending); end
      bus.we3 = 1; bus.wa3 = 4'd2; bus.wd3 = 8'h5A; bus.rsv = 1; bus.rsa = 4'd2; #1;
      n_cmp++; if (bus.rsv_ack !== 1'b1) begin n_err++; $display("FAIL wr_rsv_ack got %b want 1", bus.rsv_ack); end
      tick();
      idle(); bus.ra1 = 4'd2; bus.ren1 = 1; #1;
      n_cmp++; if (bus.pending !== 5'd2) begin n_err++; $display("FAIL wr_rsv_pending got %0d want 2", bus.pending); end
      n_cmp++; if (bus.busy1 !== 1'b1) begin n_err++; $display("FAIL wr_rsv_busy1 got %b want 1", bus.busy1); end
      n_cmp++; if (bus.rd1 !== 8'h5A) begin n_err++; $display("FAIL wr_rsv_rd1 got %h want 5a", bus.rd1); end
      idle(); bus.we3 = 1; bus.wa3 = 4'd4; bus.wd3 = 8'h44; tick();
      idle(); #1;
      n_cmp++; if (bus.pending !== 5'd1) begin n_err++; $display("FAIL wr4_pending got %0d want 1", bus.pending); end
      bus.we3 = 1; bus.wa3 = 4'd2; bus.wd3 = 8'h22; tick();
      idle(); #1;
      n_cmp++; if (bus.pending !== 5'd0) begin n_err++; $display("FAIL wr2_pending got %0d want 0", bus.pending); end
      $display("test_same_cycle done");
   endtask

   task automatic test_async_reset();
      idle(); bus.rsv = 1; bus.rsa = 4'd9; tick();
      idle(); bus.ra1 = 4'd3; bus.ra2 = 4'd9; bus.ren2 = 1; #1;
      n_cmp++; if (bus.pending !== 5'd1) begin n_err++; $display("FAIL r9_pending got %0d want 1", bus.pending); end
      n_cmp++; if (bus.rd1 !== 8'hA5) begin n_err++; $display("FAIL pre_reset_rd1 got %h want a5", bus.rd1); end
      reset = 1'b1; model_reset(); #1;
      n_cmp++; if (bus.pending !== 5'd0) begin n_err++; $display("FAIL async_pending got %0d want 0", bus.pending); end
      n_cmp++; if (bus.busy2 !== 1'b0) begin n_err++; $display("FAIL async_busy2 got %b want 0", bus.busy2); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL async_stall got %b want 0", bus.stall); end
      n_cmp++; if (bus.rd1 !== 8'h00) begin n_err++; $display("FAIL async_rd1 got %h want 00", bus.rd1); end
      reset = 1'b0; #1;
      n_cmp++; if (bus.rd1 !== 8'h00) begin n_err++; $display("FAIL post_reset_rd1 got %h want 00", bus.rd1); end
      tick();
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      logic [7:0] e_rd1, e_rd2;
      logic       e_b1, e_b2, e_ack, e_stall;
      logic [4:0] e_pend;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 79) == 0) begin
            reset = 1'b1; model_reset(); #1; reset = 1'b0;
         end
         bus.we3  = ($urandom_range(0, 2) == 0);
         bus.wa3  = 4'($urandom_range(0, 15));
         bus.wd3  = 8'($urandom);
         bus.ra1  = ($urandom_range(0, 3) == 0) ? bus.wa3 : 4'($urandom_range(0, 15));
         bus.ra2  = ($urandom_range(0, 3) == 0) ? bus.rsa : 4'($urandom_range(0, 15));
         bus.ren1 = 1'($urandom);
         bus.ren2 = 1'($urandom);
         bus.rsv  = ($urandom_range(0, 1) == 0);
         bus.rsa  = ($urandom_range(0, 4) == 0) ? bus.wa3 : 4'($urandom_range(0, 15));
         #1;
         e_rd1 = exp_rd(bus.ra1);
         e_rd2 = exp_rd(bus.ra2);
         e_b1  = exp_busy(bus.ra1);
         e_b2  = exp_busy(bus.ra2);
         e_ack = exp_ack();
         e_stall = (bus.ren1 && e_b1) || (bus.ren2 && e_b2);
         e_pend = exp_pending();
         $display("txn %0d we=%b wa=%0d wd=%h ra1=%0d ra2=%0d rsv=%b rsa=%0d rd1=%h rd2=%h ack=%b stall=%b pend=%0d",
                  t, bus.we3, bus.wa3, bus.wd3, bus.ra1, bus.ra2, bus.rsv, bus.rsa,
                  bus.rd1, bus.rd2, bus.rsv_ack, bus.stall, bus.pending);
         n_cmp++; if (bus.rd1 !== e_rd1) begin n_err++; $display("FAIL rnd_rd1 txn %0d got %h want %h", t, bus.rd1, e_rd1); end
         n_cmp++; if (bus.rd2 !== e_rd2) begin n_err++; $display("FAIL rnd_rd2 txn %0d got %h want %h", t, bus.rd2, e_rd2); end
         n_cmp++; if (bus.busy1 !== e_b1) begin n_err++; $display("FAIL rnd_busy1 txn %0d got %b want %b", t, bus.busy1, e_b1); end
         n_cmp++; if (bus.busy2 !== e_b2) begin n_err++; $display("FAIL rnd_busy2 txn %0d got %b want %b", t, bus.busy2, e_b2); end
         n_cmp++; if (bus.rsv_ack !== e_ack) begin n_err++; $display("FAIL rnd_ack txn %0d got %b want %b", t, bus.rsv_ack, e_ack); end
         n_cmp++; if (bus.stall !== e_stall) begin n_err++; $display("FAIL rnd_stall txn %0d got %b want %b", t, bus.stall, e_stall); end
         n_cmp++; if (bus.pending !== e_pend) begin n_err++; $display("FAIL rnd_pending txn %0d got %0d want %0d", t, bus.pending, e_pend); end
         tick();
      end
      idle();
      $display("test_random done");
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      idle();
      test_reset();
      test_bypass();
      test_zero_reg();
      test_reserve();
      test_same_cycle();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
